// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state type and
// the bit-counter width, sized for the largest supported operand width.
package serial_add_pkg;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned CNT_W     = $clog2(MAX_WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_e;

endpackage

// File: rtl/bit_full_adder.sv
// Single-bit full-adder cell; the controller reuses one instance every cycle.
module bit_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {carryOut,sum} = a + b + c, LSB first, WIDTH cycles.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output ovf.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  sa_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  bit_full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c;
          cnt_d   = {CNT_W{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_cout;
        cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef SERIAL_ADD_OVF_EN
        // On the last bit carry_q is the carry into the sign bit.
        ovf_d   = carry_q ^ fa_cout;
`endif
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carryOut  = carry_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): directed, random, backpressure and reset cases.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carryOut;
  logic         busy;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carryOut  (carryOut),
`ifdef SERIAL_ADD_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: plain arithmetic on the operands.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    ref_add = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] r;
    r = ref_add(x, y, ci);
    ref_ovf = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Stimulus only: issue one operation, wait for the result, consume it.
  task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                       output int lat, output logic [W-1:0] rs, output logic rc, output logic ro);
    @(negedge clk);
    a = xa; b = xb; c = xc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    rs = sum; rc = carryOut; ro = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
    ro = ovf;
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat; logic [W-1:0] rs; logic rc, ro; logic [W:0] e;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = 1'b0;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || carryOut !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got ov=%b busy=%b sum=%h co=%b, want 0 0 00 0", out_valid, busy, sum, carryOut);
    end
    rst_n = 1'b1;
    #1;
    cmp_cnt++;
    if (in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    // First accept on the very first edge after release.
    a = 8'h0F; b = 8'h01; c = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL first_accept: busy got %b want 1", busy);
    end
    @(negedge clk);
    out_ready = 1'b1;
    lat = 0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      @(posedge clk); #1;
      if (!out_valid) lat++;
    end
    e = ref_add(8'h0F, 8'h01, 1'b0);
    cmp_cnt++;
    if (lat !== W - 1 || sum !== e[W-1:0] || carryOut !== e[W]) begin
      err_cnt++;
      $display("FAIL first_op: lat=%0d sum=%h co=%b, want lat=%0d sum=%h co=%b", lat + 1, sum, carryOut, W, e[W-1:0], e[W]);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    rs = '0; rc = 1'b0; ro = 1'b0;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [4] = '{8'h0F, 8'hFF, 8'hFF, 8'h7F};
    logic [W-1:0] tb_ [4] = '{8'h01, 8'h01, 8'hFF, 8'h01};
    logic         tc [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int lat; logic [W-1:0] rs; logic rc, ro; logic [W:0] e;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb_[i], tc[i], lat, rs, rc, ro);
      e = ref_add(ta[i], tb_[i], tc[i]);
      cmp_cnt++;
      if (lat != W || rs !== e[W-1:0] || rc !== e[W]) begin
        err_cnt++;
        $display("FAIL directed_%0d: lat=%0d sum=%h co=%b, want lat=%0d sum=%h co=%b", i, lat, rs, rc, W, e[W-1:0], e[W]);
      end
    end
  endtask

`ifdef SERIAL_ADD_OVF_EN
  task automatic test_ovf();
    int lat; logic [W-1:0] rs; logic rc, ro;
    do_op(8'h7F, 8'h01, 1'b0, lat, rs, rc, ro);
    cmp_cnt++;
    if (rs !== 8'h80 || ro !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_pos: sum=%h ovf=%b want 80 1", rs, ro);
    end
    do_op(8'h80, 8'h80, 1'b0, lat, rs, rc, ro);
    cmp_cnt++;
    if (rs !== 8'h00 || rc !== 1'b1 || ro !== 1'b1) begin
      err_cnt++;
      $display("FAIL ovf_neg: sum=%h co=%b ovf=%b want 00 1 1", rs, rc, ro);
    end
  endtask
`endif

  task automatic test_random();
    int lat; logic [W-1:0] rs, xa, xb; logic rc, ro, xc; logic [W:0] e;
    for (int i = 0; i < 25; i++) begin
      xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
      do_op(xa, xb, xc, lat, rs, rc, ro);
      e = ref_add(xa, xb, xc);
      cmp_cnt++;
      if (lat != W || rs !== e[W-1:0] || rc !== e[W]) begin
        err_cnt++;
        $display("FAIL random_%0d: %h+%h+%b lat=%0d sum=%h co=%b, want lat=%0d sum=%h co=%b",
                 i, xa, xb, xc, lat, rs, rc, W, e[W-1:0], e[W]);
      end
`ifdef SERIAL_ADD_OVF_EN
      cmp_cnt++;
      if (ro !== ref_ovf(xa, xb, xc)) begin
        err_cnt++;
        $display("FAIL random_ovf_%0d: got %b want %b", i, ro, ref_ovf(xa, xb, xc));
      end
`endif
    end
  endtask

  task automatic test_backpressure();
    logic [W:0] e;
    int seen;
    e = ref_add(8'h35, 8'h4A, 1'b1);
    @(negedge clk);
    a = 8'h35; b = 8'h4A; c = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    // In RUN: keep offering garbage and out_ready; both must be ignored.
    a = 8'hAA; b = 8'h55; c = 1'b0;
    for (int k = 1; k < W; k++) begin
      @(posedge clk); #1;
      cmp_cnt++;
      if (in_ready !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
        err_cnt++;
        $display("FAIL run_ignore_%0d: in_ready=%b busy=%b ov=%b want 0 1 0", k, in_ready, busy, out_valid);
      end
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      a = W'($urandom); b = W'($urandom);
      cmp_cnt++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== e[W-1:0] || carryOut !== e[W]) begin
        err_cnt++;
        $display("FAIL done_hold_%0d: ov=%b in_ready=%b sum=%h co=%b want 1 0 %h %b",
                 k, out_valid, in_ready, sum, carryOut, e[W-1:0], e[W]);
      end
      @(posedge clk); #1;
      seen++;
    end
    // Consume while in_valid is still high: no same-cycle re-accept.
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cmp_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL no_bypass: ov=%b busy=%b in_ready=%b want 0 0 1", out_valid, busy, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int lat; logic [W-1:0] rs; logic rc, ro;
    int stray;
    @(negedge clk);
    a = 8'hC3; b = 8'h5A; c = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cmp_cnt++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || carryOut !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_midrun: ov=%b busy=%b sum=%h co=%b want 0 0 00 0", out_valid, busy, sum, carryOut);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    cmp_cnt++;
    if (stray != 0) begin
      err_cnt++;
      $display("FAIL stray_out_valid: got %0d cycles want 0", stray);
    end
    do_op(8'h03, 8'h04, 1'b0, lat, rs, rc, ro);
    cmp_cnt++;
    if (lat != W || rs !== 8'h07 || rc !== 1'b0) begin
      err_cnt++;
      $display("FAIL after_reset_op: lat=%0d sum=%h co=%b want %0d 07 0", lat, rs, rc, W);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
`ifdef SERIAL_ADD_OVF_EN
    test_ovf();
`endif
    test_random();
    test_backpressure();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
